// File: rtl/write_data_pkg.sv
// write_data_pkg: state encodings and BMP header layout shared by the
// frame sink and its header ROM.
package write_data_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        HEADER  = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int BMP_HEADER_SIZE = 54;
    localparam int BMP_BPP         = 24;
    localparam int BYTES_PER_PIXEL = 3;

    // Byte offsets of the little-endian fields inside the 54-byte header.
    localparam logic [5:0] BMP_OFF_MAGIC       = 6'd0;
    localparam logic [5:0] BMP_OFF_FILE_SIZE   = 6'd2;
    localparam logic [5:0] BMP_OFF_RESERVED    = 6'd6;
    localparam logic [5:0] BMP_OFF_DATA_OFFSET = 6'd10;
    localparam logic [5:0] BMP_OFF_DIB_SIZE    = 6'd14;
    localparam logic [5:0] BMP_OFF_WIDTH       = 6'd18;
    localparam logic [5:0] BMP_OFF_HEIGHT      = 6'd22;
    localparam logic [5:0] BMP_OFF_PLANES      = 6'd26;
    localparam logic [5:0] BMP_OFF_BPP         = 6'd28;

    localparam logic [7:0] BMP_DIB_SIZE = 8'd40;

endpackage

// File: rtl/write_data_bmp_header_rom.sv
// bmp_header_rom: combinational lookup of one byte of the 54-byte BMP header
// for a 24-bit bottom-up image of i_width x i_height pixels.
module bmp_header_rom
    import write_data_pkg::*;
(
    input  logic [5:0]  i_index,
    input  logic [31:0] i_width,
    input  logic [31:0] i_height,
    output logic [7:0]  o_byte
);

    logic [31:0] w_file_size;

    assign w_file_size = 32'(BMP_HEADER_SIZE) + (i_width * i_height * 32'(BYTES_PER_PIXEL));

    // Select the header byte; every field not listed is zero.
    always_comb begin
        o_byte = 8'h00;
        case (i_index)
            BMP_OFF_MAGIC:                o_byte = 8'h42;
            BMP_OFF_MAGIC + 6'd1:         o_byte = 8'h4D;
            BMP_OFF_FILE_SIZE:            o_byte = w_file_size[7:0];
            BMP_OFF_FILE_SIZE + 6'd1:     o_byte = w_file_size[15:8];
            BMP_OFF_FILE_SIZE + 6'd2:     o_byte = w_file_size[23:16];
            BMP_OFF_FILE_SIZE + 6'd3:     o_byte = w_file_size[31:24];
            BMP_OFF_DATA_OFFSET:          o_byte = 8'(BMP_HEADER_SIZE);
            BMP_OFF_DIB_SIZE:             o_byte = BMP_DIB_SIZE;
            BMP_OFF_WIDTH:                o_byte = i_width[7:0];
            BMP_OFF_WIDTH + 6'd1:         o_byte = i_width[15:8];
            BMP_OFF_WIDTH + 6'd2:         o_byte = i_width[23:16];
            BMP_OFF_WIDTH + 6'd3:         o_byte = i_width[31:24];
            BMP_OFF_HEIGHT:               o_byte = i_height[7:0];
            BMP_OFF_HEIGHT + 6'd1:        o_byte = i_height[15:8];
            BMP_OFF_HEIGHT + 6'd2:        o_byte = i_height[23:16];
            BMP_OFF_HEIGHT + 6'd3:        o_byte = i_height[31:24];
            BMP_OFF_PLANES:               o_byte = 8'd1;
            BMP_OFF_BPP:                  o_byte = 8'(BMP_BPP);
            default:                      o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/write_data.sv
// write_data: frame sink. Captures even/odd RGB pixel pairs into a frame
// buffer stored bottom-up as B,G,R, then streams the buffer out over a
// valid/ready byte interface. Define BMP_HEADER_EN to prefix the stream with
// a 54-byte BMP header (adds the HEADER state and bmp_header_rom).
module write_data
    import write_data_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       vertical_Pulse,
    input  logic       horizontal_Pulse,
    input  logic [7:0] data_R_Even,
    input  logic [7:0] data_G_Even,
    input  logic [7:0] data_B_Even,
    input  logic [7:0] data_R_Odd,
    input  logic [7:0] data_G_Odd,
    input  logic [7:0] data_B_Odd,
    output logic [7:0] byte_Data,
    output logic       byte_Valid,
    input  logic       byte_Ready,
    output logic       write_Done
);

    localparam int NBYTES    = IMAGE_WIDTH * IMAGE_HEIGHT * BYTES_PER_PIXEL;
    localparam int ROW_BYTES = IMAGE_WIDTH * BYTES_PER_PIXEL;
    localparam int AW        = $clog2(NBYTES);
    localparam int IW        = (AW > 6) ? AW : 6;
    localparam int CW        = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
    localparam logic [IW-1:0] LAST_PIX = IW'(NBYTES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_next;
    logic [7:0]      r_byte_data;
    logic            r_byte_valid;
    logic            r_write_done;
    logic [7:0]      r_mem [0:NBYTES-1];

    logic            w_we;
    logic            w_last_pair;
    logic            w_xfer;
    logic            w_last_byte;
    logic [AW-1:0]   w_wbase;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_fwd_off;
    logic [7:0]      w_pix_byte;
    logic [7:0]      w_next_byte;

    assign w_we        = (r_state == CAPTURE) && horizontal_Pulse && !vertical_Pulse;
    assign w_last_pair = w_we && (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_xfer      = r_byte_valid && byte_Ready;
    assign w_last_byte = (r_state == DRAIN) && (r_idx == LAST_PIX);
    // Row 0 of the image lands in the last buffer row (bottom-up storage).
    assign w_wbase     = AW'((IMAGE_HEIGHT - 1 - int'(r_row)) * ROW_BYTES
                             + int'(r_col) * BYTES_PER_PIXEL);

`ifdef BMP_HEADER_EN
    localparam logic [IW-1:0] LAST_HDR = IW'(BMP_HEADER_SIZE - 1);

    logic [5:0] w_rom_idx;
    logic [7:0] w_rom_byte;

    // Entering HEADER presents byte 0; afterwards the ROM looks one ahead.
    assign w_rom_idx = (r_state == HEADER) ? (r_idx[5:0] + 6'd1) : 6'd0;

    bmp_header_rom u_bmp_header_rom (
        .i_index  (w_rom_idx),
        .i_width  (32'(IMAGE_WIDTH)),
        .i_height (32'(IMAGE_HEIGHT)),
        .o_byte   (w_rom_byte)
    );
`endif

    // Store the captured pair as B,G,R; buffer contents survive reset as don't-care.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wbase]              <= data_B_Even;
            r_mem[w_wbase + AW'(3'd1)]  <= data_G_Even;
            r_mem[w_wbase + AW'(3'd2)]  <= data_R_Even;
            r_mem[w_wbase + AW'(3'd3)]  <= data_B_Odd;
            r_mem[w_wbase + AW'(3'd4)]  <= data_G_Odd;
            r_mem[w_wbase + AW'(3'd5)]  <= data_R_Odd;
        end
    end

    // Buffer address of the byte to present next (0 when a drain starts).
    always_comb begin
        if (r_state == DRAIN) begin
            w_rd_addr = r_idx[AW-1:0] + AW'(3'd1);
        end else begin
            w_rd_addr = '0;
        end
    end

    // Buffer read, forwarding the pair being written in the same cycle so a
    // drain that starts on the last-pair edge sees fresh data.
    always_comb begin
        w_fwd_off  = w_rd_addr - w_wbase;
        w_pix_byte = r_mem[w_rd_addr];
        if (w_we && (w_rd_addr >= w_wbase) && (w_fwd_off < AW'(3'd6))) begin
            case (w_fwd_off[2:0])
                3'd0:    w_pix_byte = data_B_Even;
                3'd1:    w_pix_byte = data_G_Even;
                3'd2:    w_pix_byte = data_R_Even;
                3'd3:    w_pix_byte = data_B_Odd;
                3'd4:    w_pix_byte = data_G_Odd;
                3'd5:    w_pix_byte = data_R_Odd;
                default: w_pix_byte = r_mem[w_rd_addr];
            endcase
        end else begin
            w_pix_byte = r_mem[w_rd_addr];
        end
    end

    // Choose the next stream byte: header ROM or frame buffer.
    always_comb begin
        w_next_byte = w_pix_byte;
        case (r_state)
`ifdef BMP_HEADER_EN
            CAPTURE: w_next_byte = w_rom_byte;
            HEADER: begin
                if (r_idx == LAST_HDR) begin
                    w_next_byte = w_pix_byte;
                end else begin
                    w_next_byte = w_rom_byte;
                end
            end
`endif
            default: w_next_byte = w_pix_byte;
        endcase
    end

    // Stream index advance; wraps to 0 when the header hands over to pixels.
    always_comb begin
        w_idx_next = r_idx + IW'(1'b1);
`ifdef BMP_HEADER_EN
        if ((r_state == HEADER) && (r_idx == LAST_HDR)) begin
            w_idx_next = '0;
        end else begin
            w_idx_next = r_idx + IW'(1'b1);
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (vertical_Pulse) w_next_state = CAPTURE;
                else                w_next_state = IDLE;
            end
            CAPTURE: begin
                if (vertical_Pulse) begin
                    w_next_state = CAPTURE;
                end else if (w_last_pair) begin
`ifdef BMP_HEADER_EN
                    w_next_state = HEADER;
`else
                    w_next_state = DRAIN;
`endif
                end else begin
                    w_next_state = CAPTURE;
                end
            end
`ifdef BMP_HEADER_EN
            HEADER: begin
                if (w_xfer && (r_idx == LAST_HDR)) w_next_state = DRAIN;
                else                               w_next_state = HEADER;
            end
`endif
            DRAIN: begin
                if (w_xfer && w_last_byte) w_next_state = DONE;
                else                       w_next_state = DRAIN;
            end
            DONE: begin
                if (vertical_Pulse) w_next_state = CAPTURE;
                else                w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture counters, stream index and registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_idx        <= '0;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_write_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (vertical_Pulse) begin
                        r_col        <= '0;
                        r_row        <= '0;
                        r_write_done <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vertical_Pulse) begin
                        r_col <= '0;
                        r_row <= '0;
                    end else if (w_we) begin
                        if (w_last_pair) begin
                            r_col        <= '0;
                            r_row        <= '0;
                            r_idx        <= '0;
                            r_byte_data  <= w_next_byte;
                            r_byte_valid <= 1'b1;
                        end else if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1'b1);
                        end else begin
                            r_col <= r_col + CW'(2'd2);
                        end
                    end
                end
                HEADER, DRAIN: begin
                    if (w_xfer) begin
                        if (w_last_byte) begin
                            r_idx        <= '0;
                            r_byte_valid <= 1'b0;
                            r_write_done <= 1'b1;
                        end else begin
                            r_idx       <= w_idx_next;
                            r_byte_data <= w_next_byte;
                        end
                    end
                end
                default: begin
                    r_byte_valid <= 1'b0;
                end
            endcase
        end
    end

    assign byte_Data  = r_byte_data;
    assign byte_Valid = r_byte_valid;
    assign write_Done = r_write_done;

endmodule

// File: tb/tb_write_data.sv
// tb_write_data: scoreboard bench for write_data with a 4x2 frame.
// Expected stream bytes are queued when a frame is driven and popped as the
// DUT hands bytes over; BMP_HEADER_EN selects the header-prefixed stream.
module tb_write_data;

    localparam int W        = 4;
    localparam int H        = 2;
    localparam int NPIXB    = W * H * 3;
    localparam int NPAIRS   = W * H / 2;
`ifdef BMP_HEADER_EN
    localparam int HDR      = 54;
`else
    localparam int HDR      = 0;
`endif
    localparam int NSTREAM  = HDR + NPIXB;
    localparam int BUDGET   = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       vertical_Pulse;
    logic       horizontal_Pulse;
    logic [7:0] data_R_Even, data_G_Even, data_B_Even;
    logic [7:0] data_R_Odd, data_G_Odd, data_B_Odd;
    logic [7:0] byte_Data;
    logic       byte_Valid;
    logic       byte_Ready;
    logic       write_Done;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fr_r [0:W*H-1];
    logic [7:0] fr_g [0:W*H-1];
    logic [7:0] fr_b [0:W*H-1];

    always #5 clk = ~clk;

    write_data #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk              (clk),
        .reset            (reset),
        .vertical_Pulse   (vertical_Pulse),
        .horizontal_Pulse (horizontal_Pulse),
        .data_R_Even      (data_R_Even),
        .data_G_Even      (data_G_Even),
        .data_B_Even      (data_B_Even),
        .data_R_Odd       (data_R_Odd),
        .data_G_Odd       (data_G_Odd),
        .data_B_Odd       (data_B_Odd),
        .byte_Data        (byte_Data),
        .byte_Valid       (byte_Valid),
        .byte_Ready       (byte_Ready),
        .write_Done       (write_Done)
    );

    // Pixel p of a frame: seed 0 gives R,G,B = 1,2,3 / 4,5,6 / ...
    function automatic logic [7:0] pix(input int seed, input int p, input int ch);
        return 8'(seed + 3 * p + ch + 1);
    endfunction

    task automatic push_expected();
        logic [7:0] hdr [0:53];
        int fsize;
        fsize = 54 + NPIXB;
        if (HDR != 0) begin
            for (int i = 0; i < 54; i++) hdr[i] = 8'h00;
            hdr[0] = 8'h42; hdr[1] = 8'h4D;
            for (int i = 0; i < 4; i++) begin
                hdr[2 + i]  = 8'(fsize >> (8 * i));
                hdr[18 + i] = 8'(W >> (8 * i));
                hdr[22 + i] = 8'(H >> (8 * i));
            end
            hdr[10] = 8'd54; hdr[14] = 8'd40; hdr[26] = 8'd1; hdr[28] = 8'd24;
            for (int i = 0; i < 54; i++) exp_q.push_back(hdr[i]);
        end
        for (int row = H - 1; row >= 0; row--) begin
            for (int col = 0; col < W; col++) begin
                exp_q.push_back(fr_b[row * W + col]);
                exp_q.push_back(fr_g[row * W + col]);
                exp_q.push_back(fr_r[row * W + col]);
            end
        end
    endtask

    // Frame start then npairs pairs; returns at the negedge after the last pair.
    task automatic send_frame(input int seed, input int npairs, input bit gapped, input bit hp_on_vp);
        int gap;
        int p0;
        @(negedge clk);
        vertical_Pulse   = 1'b1;
        horizontal_Pulse = hp_on_vp;
        data_R_Even = 8'hEE; data_G_Even = 8'hEE; data_B_Even = 8'hEE;
        data_R_Odd  = 8'hEE; data_G_Odd  = 8'hEE; data_B_Odd  = 8'hEE;
        @(negedge clk);
        vertical_Pulse   = 1'b0;
        horizontal_Pulse = 1'b0;
        for (int k = 0; k < npairs; k++) begin
            if (gapped) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
            end
            p0 = 2 * k;
            fr_r[p0] = pix(seed, p0, 0);     fr_g[p0] = pix(seed, p0, 1);     fr_b[p0] = pix(seed, p0, 2);
            fr_r[p0+1] = pix(seed, p0+1, 0); fr_g[p0+1] = pix(seed, p0+1, 1); fr_b[p0+1] = pix(seed, p0+1, 2);
            data_R_Even = fr_r[p0];   data_G_Even = fr_g[p0];   data_B_Even = fr_b[p0];
            data_R_Odd  = fr_r[p0+1]; data_G_Odd  = fr_g[p0+1]; data_B_Odd  = fr_b[p0+1];
            horizontal_Pulse = 1'b1;
            @(negedge clk);
            horizontal_Pulse = 1'b0;
        end
        if (npairs == NPAIRS) push_expected();
    endtask

    // Consume the stream; bp selects the 1,0,0,1 ready pattern. stop_after>0
    // returns once that many bytes are accepted (the last one at the next edge).
    task automatic drain_stream(input bit bp, input int stop_after);
        int cyc = 0;
        int got = 0;
        bit held = 1'b0;
        bit last_seen = 1'b0;
        bit finished = 1'b0;
        logic [7:0] held_data = 8'h00;
        logic [7:0] exp_b;
        while ((cyc < BUDGET) && !finished) begin
            if (held) begin
                n_checks++;
                if (byte_Valid !== 1'b1 || byte_Data !== held_data) begin
                    n_fails++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", byte_Valid, byte_Data, held_data);
                end
            end
            held = 1'b0;
            if (last_seen) begin
                n_checks++;
                if (write_Done !== 1'b1 || byte_Valid !== 1'b0) begin
                    n_fails++;
                    $display("FAIL end_of_stream: done=%b valid=%b, required done=1 valid=0", write_Done, byte_Valid);
                end
                if (!bp) begin
                    n_checks++;
                    if (cyc != NSTREAM) begin
                        n_fails++;
                        $display("FAIL stream_latency: %0d cycles, required %0d", cyc, NSTREAM);
                    end
                end
                finished = 1'b1;
            end else if (write_Done === 1'b1) begin
                n_checks++;
                n_fails++;
                $display("FAIL early_done: done after %0d bytes, required %0d", got, NSTREAM);
                finished = 1'b1;
            end else begin
                byte_Ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
                if (byte_Valid === 1'b1) begin
                    if (byte_Ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fails++;
                            $display("FAIL extra_byte: got %h at byte %0d, required none", byte_Data, got);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (byte_Data !== exp_b) begin
                                n_fails++;
                                $display("FAIL stream_byte[%0d]: got %h, required %h", got, byte_Data, exp_b);
                            end
                        end
                        got++;
                        if (exp_q.size() == 0) last_seen = 1'b1;
                        if ((stop_after != 0) && (got == stop_after)) finished = 1'b1;
                    end else begin
                        held      = 1'b1;
                        held_data = byte_Data;
                    end
                end
                if (!finished) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (!finished) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain_timeout: %0d bytes in %0d cycles, required %0d", got, cyc, NSTREAM);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (byte_Data !== 8'h00 || byte_Valid !== 1'b0 || write_Done !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outputs: data=%h valid=%b done=%b, required 00/0/0", byte_Data, byte_Valid, write_Done);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_raw();
        send_frame(0, NPAIRS, 1'b0, 1'b0);
        n_checks++;
        if (byte_Valid !== 1'b1) begin
            n_fails++;
            $display("FAIL first_valid: valid=%b one cycle after last pair, required 1", byte_Valid);
        end
        drain_stream(1'b0, 0);
    endtask

    task automatic test_backpressure();
        send_frame(20, NPAIRS, 1'b0, 1'b0);
        drain_stream(1'b1, 0);
    endtask

    task automatic test_restart();
        send_frame(50, 2, 1'b0, 1'b0);
        n_checks++;
        if (write_Done !== 1'b0 || byte_Valid !== 1'b0) begin
            n_fails++;
            $display("FAIL restart_clear: done=%b valid=%b, required 0/0", write_Done, byte_Valid);
        end
        send_frame(100, NPAIRS, 1'b0, 1'b0);
        drain_stream(1'b0, 0);
    endtask

    task automatic test_gapped();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        data_R_Even = 8'hEE; data_G_Even = 8'hEE; data_B_Even = 8'hEE;
        data_R_Odd  = 8'hEE; data_G_Odd  = 8'hEE; data_B_Odd  = 8'hEE;
        horizontal_Pulse = 1'b1;
        repeat (3) @(negedge clk);
        horizontal_Pulse = 1'b0;
        n_checks++;
        if (byte_Valid !== 1'b0 || write_Done !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_pairs: valid=%b done=%b, required 0/0", byte_Valid, write_Done);
        end
        send_frame(0, NPAIRS, 1'b1, 1'b1);
        drain_stream(1'b0, 0);
    endtask

    task automatic test_reset_mid_drain();
        send_frame(7, NPAIRS, 1'b0, 1'b0);
        drain_stream(1'b0, 11);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (byte_Valid !== 1'b0 || write_Done !== 1'b0) begin
            n_fails++;
            $display("FAIL async_reset: valid=%b done=%b before next edge, required 0/0", byte_Valid, write_Done);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        send_frame(9, NPAIRS, 1'b0, 1'b0);
        drain_stream(1'b0, 0);
    endtask

    initial begin
        reset            = 1'b1;
        vertical_Pulse   = 1'b0;
        horizontal_Pulse = 1'b0;
        byte_Ready       = 1'b0;
        data_R_Even = 8'h00; data_G_Even = 8'h00; data_B_Even = 8'h00;
        data_R_Odd  = 8'h00; data_G_Odd  = 8'h00; data_B_Odd  = 8'h00;
        test_reset();
        test_basic_raw();
        test_backpressure();
        test_restart();
        test_gapped();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
